// File: rtl/parity_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : parity_frame_rx
// Description : Serial parity-frame receiver (start, DATA_W data LSB first,
//               parity, stop). Checks even/odd parity and flags framing errors.
//               Define PARITY_ERR_CNT_EN to add the saturating err_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_rx #(
    parameter int DATA_W     = 3,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
`ifdef PARITY_ERR_CNT_EN
    output logic [7:0]        err_count,
`endif
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);
    localparam logic c_odd = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DATA      = 3'd1,
        S_PARITY    = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shadow;
    logic              r_par_bit;
    logic              w_par_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (!sin) w_next_state = S_DATA;
            S_DATA:      if (r_bit_cnt == c_last_bit) w_next_state = S_PARITY;
            S_PARITY:    w_next_state = S_STOP;
            S_STOP:      w_next_state = sin ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (sin) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Odd mode is the even-mode result inverted.
    assign w_par_err = (^r_shadow) ^ r_par_bit ^ c_odd;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_shadow   <= '0;
            r_par_bit  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!sin) r_bit_cnt <= '0;
                end
                S_DATA: begin
                    r_shadow[r_bit_cnt] <= sin;
                    r_bit_cnt           <= r_bit_cnt + 1'b1;
                end
                S_PARITY: begin
                    r_par_bit <= sin;
                end
                S_STOP: begin
                    // Errors never suppress the strobe; downstream decides.
                    data_out   <= r_shadow;
                    parity_err <= w_par_err;
                    frame_err  <= ~sin;
                    data_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PARITY_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (r_state == S_STOP && w_par_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_rx
// Description : Bench for parity_frame_rx; even and odd instances share one line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_rx;

    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sin = 1'b1;
    logic [DW-1:0] dout_e, dout_o;
    logic          dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0]    cnt_e, cnt_o;
`endif

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    parity_frame_rx #(.DATA_W(DW), .ODD_PARITY(0)) u_even (
        .clk(clk), .rst(rst), .sin(sin), .data_out(dout_e), .data_valid(dv_e),
        .parity_err(pe_e), .frame_err(fe_e),
`ifdef PARITY_ERR_CNT_EN
        .err_count(cnt_e),
`endif
        .busy(busy_e));

    parity_frame_rx #(.DATA_W(DW), .ODD_PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .sin(sin), .data_out(dout_o), .data_valid(dv_o),
        .parity_err(pe_o), .frame_err(fe_o),
`ifdef PARITY_ERR_CNT_EN
        .err_count(cnt_o),
`endif
        .busy(busy_o));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
    } ev_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        logic          stop;
        logic [DW-1:0] exp_data;
        logic          exp_pe;
        logic          exp_po;
        logic          exp_fe;
    } vec_t;

    ev_t  seen_e[$], seen_o[$], exp_e[$], exp_o[$];
    vec_t tbl[8];

    // Every valid strobe is logged; a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (dv_e) seen_e.push_back('{cyc, dout_e, pe_e, fe_e});
        if (dv_o) seen_o.push_back('{cyc, dout_o, pe_o, fe_o});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_ev(input string nm, input ev_t a, input ev_t e);
        chk({nm, "_cyc"},  a.cyc, e.cyc);
        chk({nm, "_data"}, int'(a.d), int'(e.d));
        chk({nm, "_perr"}, int'(a.pe), int'(e.pe));
        chk({nm, "_ferr"}, int'(a.fe), int'(e.fe));
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                              output int sc);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        sc = cyc;
    endtask

    task automatic chk_one(input string nm, input int sc, input logic [DW-1:0] d,
                           input logic pe, input logic po, input logic fe);
        chk({nm, "_cnt_even"}, seen_e.size(), 1);
        chk({nm, "_cnt_odd"},  seen_o.size(), 1);
        if (seen_e.size() >= 1) chk_ev({nm, "_even"}, seen_e[0], '{sc + 1, d, pe, fe});
        if (seen_o.size() >= 1) chk_ev({nm, "_odd"},  seen_o[0], '{sc + 1, d, po, fe});
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_dout"},  int'(dout_e), 0);
        chk({nm, "_dv"},    int'(dv_e),   0);
        chk({nm, "_perr"},  int'(pe_e),   0);
        chk({nm, "_ferr"},  int'(fe_e),   0);
        chk({nm, "_busy"},  int'(busy_e), 0);
        chk({nm, "_dout_o"}, int'(dout_o), 0);
        chk({nm, "_busy_o"}, int'(busy_o), 0);
`ifdef PARITY_ERR_CNT_EN
        chk({nm, "_errcnt"}, int'(cnt_e), 0);
`endif
    endtask

    initial begin
        int sc, s1, s2;
        logic [DW-1:0] d;
        logic p, s;

        //           data    par   stop  exp_data pe_even pe_odd ferr
        tbl[0] = '{3'b101, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{3'b101, 1'b1, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{3'b110, 1'b1, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{3'b110, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{3'b111, 1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{3'b011, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{3'b100, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        for (int i = 0; i < 8; i++) begin
            seen_e.delete();
            seen_o.delete();
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, sc);
            repeat (3) drive_bit(1'b1);
            chk_one($sformatf("tbl%0d", i), sc, tbl[i].exp_data,
                    tbl[i].exp_pe, tbl[i].exp_po, tbl[i].exp_fe);
            chk($sformatf("tbl%0d_hold", i), int'(dout_e), int'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_idle_busy", i), int'(busy_e), 0);
        end

        // Stop bit low, line held low four more cycles, then released.
        seen_e.delete();
        seen_o.delete();
        send_frame(3'b101, 1'b0, 1'b0, sc);
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'b0);
            chk($sformatf("wait_busy%0d", i), int'(busy_e), 1);
        end
        drive_bit(1'b1);
        chk("wait_exit_busy_hi", int'(busy_e), 1);
        drive_bit(1'b1);
        chk("wait_exit_busy_lo", int'(busy_e), 0);
        drive_bit(1'b1);
        chk("wait_no_start", int'(busy_o), 0);
        chk_one("wait", sc, 3'b101, 1'b0, 1'b1, 1'b1);

        // Back-to-back frames with no idle gap.
        seen_e.delete();
        seen_o.delete();
        send_frame(3'b101, 1'b0, 1'b1, s1);
        send_frame(3'b110, 1'b0, 1'b1, s2);
        repeat (3) drive_bit(1'b1);
        chk("b2b_cnt", seen_e.size(), 2);
        if (seen_e.size() == 2) begin
            chk_ev("b2b_first",  seen_e[0], '{s1 + 1, 3'b101, 1'b0, 1'b0});
            chk_ev("b2b_second", seen_e[1], '{s2 + 1, 3'b110, 1'b0, 1'b0});
            chk("b2b_gap", seen_e[1].cyc - seen_e[0].cyc, 6);
        end

        // Reset sampled at the second data-bit edge of a frame.
        seen_e.delete();
        seen_o.delete();
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge clk);
        sin = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sin = 1'b1;
        chk_reset_outputs("midrst");
        repeat (4) drive_bit(1'b1);
        chk("midrst_no_valid", seen_e.size(), 0);
        send_frame(3'b011, 1'b0, 1'b1, sc);
        repeat (2) drive_bit(1'b1);
        chk_one("after_rst", sc, 3'b011, 1'b0, 1'b1, 1'b0);

`ifdef PARITY_ERR_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_frame(3'b101, 1'b1, 1'b1, sc);
        drive_bit(1'b1);
        chk("errcnt_one", int'(cnt_e), 1);
        for (int i = 1; i < 260; i++) send_frame(3'b101, 1'b1, 1'b1, sc);
        repeat (2) drive_bit(1'b1);
        chk("errcnt_sat_even", int'(cnt_e), 255);
        chk("errcnt_odd_zero", int'(cnt_o), 0);
`endif

        // Randomized stream against a frame-level reference.
        seen_e.delete();
        seen_o.delete();
        exp_e.delete();
        exp_o.delete();
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) drive_bit(1'b1);
            d = DW'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, p, s, sc);
            exp_e.push_back('{sc + 1, d, (^d) ^ p, ~s});
            exp_o.push_back('{sc + 1, d, ~((^d) ^ p), ~s});
            if (!s) begin
                repeat ($urandom_range(0, 3)) drive_bit(1'b0);
                drive_bit(1'b1);
            end
        end
        repeat (4) drive_bit(1'b1);
        chk("rand_cnt_even", seen_e.size(), exp_e.size());
        chk("rand_cnt_odd",  seen_o.size(), exp_o.size());
        for (int i = 0; i < exp_e.size(); i++) begin
            if (i < seen_e.size()) chk_ev($sformatf("rand%0d_even", i), seen_e[i], exp_e[i]);
            if (i < seen_o.size()) chk_ev($sformatf("rand%0d_odd", i),  seen_o[i], exp_o[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
